// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit multiplexed seven-segment display.
package display_pkg;

  typedef enum logic [3:0] {
    SHOW0  = 4'b0001,
    BLANK0 = 4'b0010,
    SHOW1  = 4'b0100,
    BLANK1 = 4'b1000
  } disp_state_t;

  localparam logic [1:0] ANODE_OFF = 2'b11;

  // Board timing at 24 MHz: ~1 ms per lit digit, ~10 us dead time
  localparam int DEF_REFRESH_CYCLES = 24000;
  localparam int DEF_BLANK_CYCLES   = 240;

endpackage

// File: rtl/seven_seg_display.sv
// Hex to active-low seven-segment decoder; seg_o bit order is {a,b,c,d,e,f,g}.
module seven_seg_display (
  input  logic [3:0] s_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    case (s_i)
      4'h0: seg_o = 7'b0000001;
      4'h1: seg_o = 7'b1001111;
      4'h2: seg_o = 7'b0010010;
      4'h3: seg_o = 7'b0000110;
      4'h4: seg_o = 7'b1001100;
      4'h5: seg_o = 7'b0100100;
      4'h6: seg_o = 7'b0100000;
      4'h7: seg_o = 7'b0001111;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0000100;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b1100000;
      4'hC: seg_o = 7'b0110001;
      4'hD: seg_o = 7'b1000010;
      4'hE: seg_o = 7'b0110000;
      4'hF: seg_o = 7'b0111000;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/display_mux_ctrl.sv
// Two-digit display multiplexer: SHOW0/BLANK0/SHOW1/BLANK1 slot FSM with
// new digit values held pending until the frame boundary (last BLANK1 cycle).
module display_mux_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int CNT_W          = $clog2(REFRESH_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [1:0] en,
  output logic [3:0] s,
  output logic [6:0] seg,
  output logic [1:0] an_n,
  output logic       pending,
  output logic       frame_start
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  disp_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       act0_q, act0_d, act1_q, act1_d;
  logic [1:0]       actEn_q, actEn_d;
  logic [3:0]       pendD0_q, pendD0_d, pendD1_q, pendD1_d;
  logic [1:0]       pendEn_q, pendEn_d;
  logic             pending_q, pending_d;
  logic             frameStart_q, frameStart_d;
  logic             slotLast, boundary;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BLANK1;
      cnt_q        <= '0;
      act0_q       <= '0;
      act1_q       <= '0;
      actEn_q      <= 2'b00;
      pendD0_q     <= '0;
      pendD1_q     <= '0;
      pendEn_q     <= 2'b00;
      pending_q    <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act0_q       <= act0_d;
      act1_q       <= act1_d;
      actEn_q      <= actEn_d;
      pendD0_q     <= pendD0_d;
      pendD1_q     <= pendD1_d;
      pendEn_q     <= pendEn_d;
      pending_q    <= pending_d;
      frameStart_q <= frameStart_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    act0_d       = act0_q;
    act1_d       = act1_q;
    actEn_d      = actEn_q;
    pendD0_d     = pendD0_q;
    pendD1_d     = pendD1_q;
    pendEn_d     = pendEn_q;
    pending_d    = pending_q;

    if ((state_q == SHOW0) || (state_q == SHOW1)) begin
      slotLast = (cnt_q == SHOW_LAST);
    end else begin
      slotLast = (cnt_q == BLANK_LAST);
    end
    boundary     = (state_q == BLANK1) && slotLast;
    cnt_d        = slotLast ? '0 : cnt_q + 1'b1;
    frameStart_d = boundary;

    if (slotLast) begin
      case (state_q)
        SHOW0:   state_d = BLANK0;
        BLANK0:  state_d = SHOW1;
        SHOW1:   state_d = BLANK1;
        BLANK1:  state_d = SHOW0;
        default: state_d = BLANK1;
      endcase
    end

    // A load landing on the boundary bypasses the pending register entirely
    if (boundary) begin
      if (load) begin
        act0_d  = d0;
        act1_d  = d1;
        actEn_d = en;
      end else if (pending_q) begin
        act0_d  = pendD0_q;
        act1_d  = pendD1_q;
        actEn_d = pendEn_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pendD0_d  = d0;
      pendD1_d  = d1;
      pendEn_d  = en;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    an_n = ANODE_OFF;
    s    = act0_q;
    case (state_q)
      SHOW0:   begin an_n = {1'b1, ~actEn_q[0]}; s = act0_q; end
      BLANK0:  s = act0_q;
      SHOW1:   begin an_n = {~actEn_q[1], 1'b1}; s = act1_q; end
      BLANK1:  s = act1_q;
      default: an_n = ANODE_OFF;
    endcase
  end

  assign pending     = pending_q;
  assign frame_start = frameStart_q;

  seven_seg_display u_decoder (
    .s_i   (s),
    .seg_o (seg)
  );

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Directed bench for display_mux_ctrl with REFRESH_CYCLES=4, BLANK_CYCLES=2 (12-cycle frame).
module tb_display_mux_ctrl;

  localparam int RC = 4;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] d0, d1;
  logic [1:0] en;
  logic [3:0] s;
  logic [6:0] seg;
  logic [1:0] an_n;
  logic       pending;
  logic       frame_start;

  int compared   = 0;
  int mismatched = 0;
  bit guardOn    = 1'b0;

  always #5 clk = ~clk;

  display_mux_ctrl #(
    .REFRESH_CYCLES (RC),
    .BLANK_CYCLES   (BC),
    .CNT_W          (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .d0          (d0),
    .d1          (d1),
    .en          (en),
    .s           (s),
    .seg         (seg),
    .an_n        (an_n),
    .pending     (pending),
    .frame_start (frame_start)
  );

  // Reference segment patterns, {a,b,c,d,e,f,g}, active-low
  function automatic logic [6:0] segRef(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'b0000001;  4'h1: r = 7'b1001111;
      4'h2: r = 7'b0010010;  4'h3: r = 7'b0000110;
      4'h4: r = 7'b1001100;  4'h5: r = 7'b0100100;
      4'h6: r = 7'b0100000;  4'h7: r = 7'b0001111;
      4'h8: r = 7'b0000000;  4'h9: r = 7'b0000100;
      4'hA: r = 7'b0001000;  4'hB: r = 7'b1100000;
      4'hC: r = 7'b0110001;  4'hD: r = 7'b1000010;
      4'hE: r = 7'b0110000;  default: r = 7'b0111000;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [3:0] v0, input logic [3:0] v1,
                               input logic [1:0] e);
    load = ld;
    d0   = v0;
    d1   = v1;
    en   = e;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Both anodes low at once would short two digits onto one segment bus
  always @(negedge clk) begin
    if (guardOn) begin
      compared++;
      assert (an_n !== 2'b00) else begin
        mismatched++;
        $error("[TB] FAIL an_both_low: observed %b expected not 00", an_n);
      end
    end
  end

  // Checks one full frame from its first SHOW0 cycle; ldVal packs {d0,d1,en}
  task automatic checkFrame(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                            input logic [1:0] ae, input int ldAt1, input logic [9:0] ldVal1,
                            input int ldAt2, input logic [9:0] ldVal2);
    logic       pend;
    logic [1:0] expAn;
    logic [3:0] expS;
    pend = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 4)       expAn = {1'b1, ~ae[0]};
      else if (i < 6)  expAn = 2'b11;
      else if (i < 10) expAn = {~ae[1], 1'b1};
      else             expAn = 2'b11;
      expS = (i < 6) ? a0 : a1;
      checkOutput($sformatf("%s[%0d].an_n", tag, i), 16'(an_n), 16'(expAn));
      checkOutput($sformatf("%s[%0d].s", tag, i), 16'(s), 16'(expS));
      checkOutput($sformatf("%s[%0d].seg", tag, i), 16'(seg), 16'(segRef(expS)));
      checkOutput($sformatf("%s[%0d].pending", tag, i), 16'(pending), 16'(pend));
      checkOutput($sformatf("%s[%0d].frame_start", tag, i), 16'(frame_start), 16'(i == 0));
      if (i == ldAt1)      applyStimulus(1'b1, ldVal1[9:6], ldVal1[5:2], ldVal1[1:0]);
      else if (i == ldAt2) applyStimulus(1'b1, ldVal2[9:6], ldVal2[5:2], ldVal2[1:0]);
      else                 applyStimulus(1'b0, 4'h0, 4'h0, 2'b00);
      tick();
      if (i == ldAt1 || i == ldAt2) pend = (i != 11);
      else if (i == 11)             pend = 1'b0;
    end
    applyStimulus(1'b0, 4'h0, 4'h0, 2'b00);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 4'h0, 4'h0, 2'b00);
    repeat (3) tick();
    checkOutput("rst.an_n", 16'(an_n), 16'h3);
    checkOutput("rst.s", 16'(s), 16'h0);
    checkOutput("rst.pending", 16'(pending), 16'h0);
    checkOutput("rst.frame_start", 16'(frame_start), 16'h0);

    @(posedge clk);
    #1 reset = 1'b0;
    guardOn = 1'b1;
    checkOutput("post_rst0.an_n", 16'(an_n), 16'h3);
    checkOutput("post_rst0.frame_start", 16'(frame_start), 16'h0);
    tick();
    checkOutput("post_rst1.an_n", 16'(an_n), 16'h3);
    checkOutput("post_rst1.frame_start", 16'(frame_start), 16'h0);
    tick();

    checkFrame("idle",   4'h0, 4'h0, 2'b00, -1, 10'h0, -1, 10'h0);
    checkFrame("loadA",  4'h0, 4'h0, 2'b00,  6, {4'h3, 4'hA, 2'b11}, -1, 10'h0);
    checkFrame("show3A", 4'h3, 4'hA, 2'b11,  2, {4'h1, 4'h2, 2'b11},  8, {4'h5, 4'h6, 2'b11});
    checkFrame("show56", 4'h5, 4'h6, 2'b11, 11, {4'h7, 4'h8, 2'b11}, -1, 10'h0);
    checkFrame("show78", 4'h7, 4'h8, 2'b11,  3, {4'h9, 4'hF, 2'b01}, -1, 10'h0);
    checkFrame("en01",   4'h9, 4'hF, 2'b01,  1, {4'hC, 4'hD, 2'b11}, -1, 10'h0);

    repeat (6) tick();
    checkOutput("pre_rst.an_n", 16'(an_n), 16'h1);
    checkOutput("pre_rst.s", 16'(s), 16'hD);
    applyStimulus(1'b1, 4'h1, 4'h2, 2'b11);
    tick();
    applyStimulus(1'b0, 4'h0, 4'h0, 2'b00);
    checkOutput("pre_rst.pending", 16'(pending), 16'h1);
    checkOutput("pre_rst.an_n_still", 16'(an_n), 16'h1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst.an_n", 16'(an_n), 16'h3);
    checkOutput("async_rst.pending", 16'(pending), 16'h0);
    checkOutput("async_rst.s", 16'(s), 16'h0);
    checkOutput("async_rst.frame_start", 16'(frame_start), 16'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rel0.an_n", 16'(an_n), 16'h3);
    tick();
    checkOutput("rel1.an_n", 16'(an_n), 16'h3);
    tick();
    checkFrame("postrst", 4'h0, 4'h0, 2'b00, -1, 10'h0, -1, 10'h0);

    guardOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/display_mux_ctrl.md
Name: display_mux_ctrl

Overview:
- Time-multiplexes one shared seven_seg_display decoder across two common-anode digits: digit0 is the right digit, digit1 the left digit.
- Sequences the decoder input and the two anode enables, with a dead-time blanking slot between digits to suppress ghosting.
- Accepts new digit values through a load handshake and applies them only at a frame boundary, so a frame never shows half-old, half-new digits.
- Sits between the keypad/digit-history logic and the board's segment/anode pins.

Parameters:
- REFRESH_CYCLES, 24000, clk cycles each digit is lit per slot (~1 ms at 24 MHz); must be >= 2.
- BLANK_CYCLES, 240, clk cycles both anodes are off between digit slots; must be >= 1.
- CNT_W, $clog2(REFRESH_CYCLES), slot-counter width; must hold max(REFRESH_CYCLES, BLANK_CYCLES)-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  one-cycle strobe: capture d0/d1/en into the pending register.
- d0  in  4  hex value for digit0.
- d1  in  4  hex value for digit1.
- en  in  2  per-digit enable; 0 keeps that digit dark in its slot.
- s  out  4  hex value to the shared decoder.
- seg  out  7  active-low segments from the seven_seg_display instance.
- an_n  out  2  active-low anode enables; bit0 = digit0, bit1 = digit1.
- pending  out  1  a loaded value is waiting for the next frame boundary.
- frame_start  out  1  one-cycle pulse on the first cycle of SHOW0.

Behaviour:
- FSM, one-hot, registered: SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0.
  - SHOW states last REFRESH_CYCLES cycles; BLANK states last BLANK_CYCLES cycles.
  - Slot counter clears on every state change; exit when count == duration-1.
- Frame length = 2*(REFRESH_CYCLES+BLANK_CYCLES) cycles.
- Frame boundary = the last cycle of BLANK1.
- Reset, asynchronous:
  - state=BLANK1, count=0.
  - active digit registers act0=act1=0, act_en=2'b00, pending=0.
  - an_n=2'b11, s=0, frame_start=0.
  - First SHOW0 begins BLANK_CYCLES cycles after reset deasserts.
- Outputs are decoded from registered state only, so an_n never glitches.
  - SHOW0: an_n=2'b1 & ~act_en[0] packed as {1, ~act_en[0]}; s=act0.
  - SHOW1: an_n={~act_en[1], 1}; s=act1.
  - BLANK0: an_n=2'b11; s holds act0.
  - BLANK1: an_n=2'b11; s holds act1.
  - Both anodes are never low in the same cycle.
- Load handshake:
  - load=1 captures d0/d1/en into the pending register and sets pending=1 the next cycle.
  - A later load before the boundary overwrites the pending value; last write wins.
- Apply:
  - At the frame boundary with pending=1, copy pending to act0/act1/act_en and clear pending.
  - With pending=0 at the boundary, act* is unchanged.
- load coincident with the boundary: the incoming d0/d1/en go directly to act*, and pending clears.
- frame_start = registered pulse, high exactly on the first SHOW0 cycle of each frame.
- Disabled digit (en bit 0): its slot timing is unchanged and its anode stays high.
- seg = combinational decode of s through the seven_seg_display instance: no added latency, active-low, hex 0-F.
- Reset mid-frame: immediate return to the reset state and blanking; a pending value is discarded.

Decomposition:
- Shared package display_pkg:
  - state enum disp_state_t {SHOW0, BLANK0, SHOW1, BLANK1}, one-hot encoded.
  - localparam ANODE_OFF = 2'b11.
  - default timing constants for the 24 MHz board clock.
- One sub-module: the existing seven_seg_display decoder, instantiated once (s -> seg).
- FSM, slot counter and pending/active registers live in display_mux_ctrl.

Test Plan (REFRESH_CYCLES=4, BLANK_CYCLES=2, frame = 12 cycles):
- Reset then idle:
  - an_n=11 for 2 cycles after deassert, then frame_start pulses.
  - an_n sequence per frame is 11 x4, 11 x2, 11 x4, 11 x2, since en=00 after reset.
  - s=0 throughout.
- load d0=4'h3, d1=4'hA, en=11 during SHOW1:
  - pending=1 until the boundary.
  - Next frame shows an_n=10 with s=3, seg=7'b0000110 for 4 cycles.
  - Then 11 x2, then an_n=01 with s=A, seg=7'b0001000 for 4 cycles.
  - Then 11 x2; pending=0.
- Two loads in one frame, (1,2) then (5,6): only 5/6 are displayed next frame.
- load asserted on the boundary cycle with d0=7, d1=8: the following SHOW0 shows s=7 and pending never rises.
- en=01 with d1=F: the SHOW1 slot keeps an_n=11 for 4 cycles and frame timing is unchanged.
- Assert reset during SHOW1 with pending=1:
  - an_n=11 immediately (asynchronous) and pending=0.
  - After release, the old act* values are cleared to 0.
- Throughout all scenarios: an_n never equals 00.
